// File: rtl/wddl_pkg.sv
// Shared definitions for the WDDL dual-rail pipeline register.
//   wddl_state_e : precharge/evaluate FSM states (2-bit encoding)
//   TO_CNT_W     : width of the ARM-state timeout counter
//   SPACER_CODE  : {p,n} rail pair representing the precharge spacer
package wddl_pkg;

  typedef enum logic [1:0] {
    PRE  = 2'd0,
    ARM  = 2'd1,
    EVAL = 2'd2,
    SPC  = 2'd3
  } wddl_state_e;

  localparam int unsigned TO_CNT_W    = 16;
  localparam logic [1:0]  SPACER_CODE = 2'b00;

endpackage

// File: rtl/wddl_rail_check.sv
// Combinational word-level classifier for a dual-rail vector.
//   p_in, n_in  : true / false rails (WIDTH bits each)
//   all_spacer  : every bit pair is the spacer code
//   complete    : every bit pair has exactly one rail high
//   any_illegal : at least one bit pair has both rails high
module wddl_rail_check
  import wddl_pkg::*;
#(
  parameter int unsigned WIDTH = 1
) (
  input  logic [WIDTH-1:0] p_in,
  input  logic [WIDTH-1:0] n_in,
  output logic             all_spacer,
  output logic             complete,
  output logic             any_illegal
);

  always_comb begin
    all_spacer  = 1'b1;
    complete    = 1'b1;
    any_illegal = 1'b0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if ({p_in[i], n_in[i]} != SPACER_CODE) all_spacer  = 1'b0;
      if (p_in[i] == n_in[i])                complete    = 1'b0;
      if (p_in[i] & n_in[i])                 any_illegal = 1'b1;
    end
  end

endmodule

// File: rtl/wddl_dr_reg.sv
// Dual-rail WDDL pipeline register. Waits for an input spacer, captures a
// complete codeword, presents it under valid/ready, then drives an output
// spacer for PRECH_CYCLES cycles. Flags illegal (1,1) pairs and evaluations
// that never complete with a sticky error.
//   clk, rst           : clock, asynchronous active-high reset
//   d_p_in, d_n_in     : dual-rail word from the XOR network
//   in_valid, in_ready : upstream evaluate indication / capture window (ARM)
//   q_p_out, q_n_out   : registered word, all-zero except in EVAL
//   out_valid          : held word presented (EVAL)
//   out_ready          : downstream accept
//   err_out            : sticky error, cleared only by rst
module wddl_dr_reg
  import wddl_pkg::*;
#(
  parameter int unsigned WIDTH        = 1,
  parameter int unsigned PRECH_CYCLES = 1,
  parameter int unsigned TIMEOUT      = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_p_in,
  input  logic [WIDTH-1:0] d_n_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] q_p_out,
  output logic [WIDTH-1:0] q_n_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             err_out
);

  localparam logic [3:0]          SPC_LOAD = 4'(PRECH_CYCLES - 1);
  localparam logic [TO_CNT_W-1:0] TO_LAST  = TO_CNT_W'(TIMEOUT - 1);

  wddl_state_e         state_q, state_d;
  logic [WIDTH-1:0]    hold_p_q, hold_p_d;
  logic [WIDTH-1:0]    hold_n_q, hold_n_d;
  logic [3:0]          spc_cnt_q, spc_cnt_d;
  logic [TO_CNT_W-1:0] to_cnt_q, to_cnt_d;
  logic                err_q, err_d;

  logic all_spacer;
  logic complete;
  logic any_illegal;

  wddl_rail_check #(
    .WIDTH (WIDTH)
  ) u_in_check (
    .p_in        (d_p_in),
    .n_in        (d_n_in),
    .all_spacer  (all_spacer),
    .complete    (complete),
    .any_illegal (any_illegal)
  );

  always_comb begin
    state_d   = state_q;
    hold_p_d  = hold_p_q;
    hold_n_d  = hold_n_q;
    spc_cnt_d = spc_cnt_q;
    // Timeout count clears unless ARM extends an incomplete evaluate below.
    to_cnt_d  = '0;
    err_d     = err_q | any_illegal;

    case (state_q)
      PRE: begin
        if (all_spacer) state_d = ARM;
      end
      ARM: begin
        if (in_valid && complete && !any_illegal) begin
          hold_p_d = d_p_in;
          hold_n_d = d_n_in;
          state_d  = EVAL;
        end else if (in_valid && !complete) begin
          // An illegal pair is never complete, so it keeps the count running.
          if (to_cnt_q == TO_LAST) begin
            err_d   = 1'b1;
            state_d = PRE;
          end else begin
            to_cnt_d = to_cnt_q + 1'b1;
          end
        end
      end
      EVAL: begin
        if (out_ready) begin
          spc_cnt_d = SPC_LOAD;
          state_d   = SPC;
        end
      end
      SPC: begin
        if (spc_cnt_q == '0) state_d = PRE;
        else                 spc_cnt_d = spc_cnt_q - 1'b1;
      end
      default: state_d = PRE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= PRE;
      hold_p_q  <= '0;
      hold_n_q  <= '0;
      spc_cnt_q <= '0;
      to_cnt_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      hold_p_q  <= hold_p_d;
      hold_n_q  <= hold_n_d;
      spc_cnt_q <= spc_cnt_d;
      to_cnt_q  <= to_cnt_d;
      err_q     <= err_d;
    end
  end

  // Decoded from registered state only; reset forces spacer asynchronously.
  assign in_ready  = (state_q == ARM);
  assign out_valid = (state_q == EVAL);
  assign q_p_out   = out_valid ? hold_p_q : '0;
  assign q_n_out   = out_valid ? hold_n_q : '0;
  assign err_out   = err_q;

endmodule

// File: tb/tb_wddl_dr_reg.sv
module tb_wddl_dr_reg;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] d_p_in, d_n_in;
  logic       in_valid, in_ready;
  logic [3:0] q_p_out, q_n_out;
  logic       out_valid, out_ready, err_out;

  typedef struct {
    logic [3:0] p;
    logic [3:0] n;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  wddl_dr_reg #(
    .WIDTH        (4),
    .PRECH_CYCLES (1),
    .TIMEOUT      (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .d_p_in    (d_p_in),
    .d_n_in    (d_n_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .q_p_out   (q_p_out),
    .q_n_out   (q_n_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .err_out   (err_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] p, input logic [3:0] n, input logic v);
    d_p_in   = p;
    d_n_in   = n;
    in_valid = v;
  endtask

  task automatic expect_word(input logic [3:0] p, input logic [3:0] n);
    exp_t e;
    e.p = p;
    e.n = n;
    sb.push_back(e);
  endtask

  // Monitor: compares presented word with the scoreboard head, pops on handshake.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (out_valid) begin
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL mon_unexpected: out_valid with q_p=%0h q_n=%0h, expected none", q_p_out, q_n_out);
        end else begin
          chk("mon_q_p", {28'd0, q_p_out}, {28'd0, sb[0].p});
          chk("mon_q_n", {28'd0, q_n_out}, {28'd0, sb[0].n});
          if (out_ready) void'(sb.pop_front());
        end
      end else begin
        chk("mon_spacer", {24'd0, q_p_out, q_n_out}, 32'd0);
      end
    end
  end

  initial begin
    rst       = 1'b1;
    out_ready = 1'b1;
    drive(4'h0, 4'h0, 1'b0);

    // Reset state
    step();
    chk("rst_q_p", {28'd0, q_p_out}, 32'd0);
    chk("rst_q_n", {28'd0, q_n_out}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_err", {31'd0, err_out}, 32'd0);
    step();
    rst = 1'b0;

    // Nominal: PRE lasts one cycle with spacer inputs
    step();
    chk("nom_arm", {31'd0, in_ready}, 32'd1);
    drive(4'b1010, 4'b0101, 1'b1);
    expect_word(4'b1010, 4'b0101);
    step();
    chk("nom_out_valid", {31'd0, out_valid}, 32'd1);
    chk("nom_q_p", {28'd0, q_p_out}, 32'hA);
    chk("nom_q_n", {28'd0, q_n_out}, 32'h5);
    chk("nom_in_ready_eval", {31'd0, in_ready}, 32'd0);
    drive(4'h0, 4'h0, 1'b0);
    step();
    chk("nom_spc_valid", {31'd0, out_valid}, 32'd0);
    chk("nom_spc_q", {24'd0, q_p_out, q_n_out}, 32'd0);
    step();
    chk("nom_pre_ready", {31'd0, in_ready}, 32'd0);
    step();
    chk("nom_rearm", {31'd0, in_ready}, 32'd1);
    chk("nom_err", {31'd0, err_out}, 32'd0);

    // Backpressure, with inputs changing during EVAL
    out_ready = 1'b0;
    drive(4'b0110, 4'b1001, 1'b1);
    expect_word(4'b0110, 4'b1001);
    step();
    drive(4'b1111, 4'b0000, 1'b0);
    for (int i = 0; i < 10; i++) begin
      chk("bp_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_q", {24'd0, q_p_out, q_n_out}, 32'h69);
      step();
    end
    out_ready = 1'b1;
    step();
    chk("bp_spc_valid", {31'd0, out_valid}, 32'd0);
    chk("bp_spc_ready", {31'd0, in_ready}, 32'd0);

    // Spacer gating: inputs still hold a codeword after SPC
    step();
    for (int i = 0; i < 5; i++) begin
      chk("gate_pre_wait", {31'd0, in_ready}, 32'd0);
      step();
    end
    chk("gate_pre_wait", {31'd0, in_ready}, 32'd0);
    drive(4'h0, 4'h0, 1'b0);
    step();
    chk("gate_arm", {31'd0, in_ready}, 32'd1);

    // Illegal pair on bit 2 while in ARM
    drive(4'b0110, 4'b0101, 1'b1);
    step();
    chk("ill_err", {31'd0, err_out}, 32'd1);
    chk("ill_stay_arm", {31'd0, in_ready}, 32'd1);
    chk("ill_no_valid", {31'd0, out_valid}, 32'd0);
    step();
    chk("ill_err_sticky", {31'd0, err_out}, 32'd1);
    chk("ill_stay_arm2", {31'd0, in_ready}, 32'd1);

    // Legal word after the illegal one, then async reset mid-EVAL
    out_ready = 1'b0;
    drive(4'b1001, 4'b0110, 1'b1);
    expect_word(4'b1001, 4'b0110);
    step();
    chk("ar_eval", {31'd0, out_valid}, 32'd1);
    chk("ar_err_before", {31'd0, err_out}, 32'd1);
    #2;
    rst = 1'b1;
    sb.delete();
    #1;
    chk("ar_q_p", {28'd0, q_p_out}, 32'd0);
    chk("ar_q_n", {28'd0, q_n_out}, 32'd0);
    chk("ar_out_valid", {31'd0, out_valid}, 32'd0);
    chk("ar_err", {31'd0, err_out}, 32'd0);
    chk("ar_in_ready", {31'd0, in_ready}, 32'd0);
    step();
    rst       = 1'b0;
    out_ready = 1'b1;
    drive(4'h0, 4'h0, 1'b0);
    step();
    chk("ar_restart_arm", {31'd0, in_ready}, 32'd1);

    // Timeout: bit 0 left as spacer with in_valid high
    drive(4'b1110, 4'b0000, 1'b1);
    for (int i = 1; i < 8; i++) begin
      step();
      chk("to_err_early", {31'd0, err_out}, 32'd0);
      chk("to_in_arm", {31'd0, in_ready}, 32'd1);
    end
    step();
    chk("to_err", {31'd0, err_out}, 32'd1);
    chk("to_pre", {31'd0, in_ready}, 32'd0);
    chk("to_no_valid", {31'd0, out_valid}, 32'd0);
    step();
    chk("to_pre_hold", {31'd0, in_ready}, 32'd0);
    drive(4'h0, 4'h0, 1'b0);
    step();
    chk("to_rearm", {31'd0, in_ready}, 32'd1);

    // Recovery word after timeout
    drive(4'b0001, 4'b1110, 1'b1);
    expect_word(4'b0001, 4'b1110);
    step();
    chk("rec_valid", {31'd0, out_valid}, 32'd1);
    chk("rec_q", {24'd0, q_p_out, q_n_out}, 32'h1E);
    drive(4'h0, 4'h0, 1'b0);
    step();
    chk("rec_done", {31'd0, out_valid}, 32'd0);
    chk("rec_err_sticky", {31'd0, err_out}, 32'd1);
    step();
    step();
    chk("sb_drained", sb.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
